// File: rtl/alu_mc_if.sv
// alu_mc_if -- request/response bundle for alu_mc.
//   master : drives in_valid, op, a, b, out_ready; observes in_ready and the result.
//   slave  : the ALU side; drives in_ready, out_valid, res and the n/z/p/dz flags.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             n;
  logic             z;
  logic             p;
  logic             dz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, n, z, p, dz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, n, z, p, dz
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with a valid/ready request and result handshake.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : alu_mc_if slave port (in_valid/in_ready/op/a/b in,
//            out_valid/out_ready/res/n/z/p/dz out)
// Single-cycle ops complete one cycle after acceptance. MUL (shift-add) and
// DIV/MOD (restoring division) iterate one bit per cycle for WIDTH cycles.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// BUSY  | iterating MUL/DIV/MOD, counter counts WIDTH down to 0
// DONE  | out_valid=1, result held until out_ready
module alu_mc #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_PA0  = 4'd11;
  localparam logic [3:0] OP_PA1  = 4'd12;
  localparam logic [3:0] OP_HOLD = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       op_r, op_nxt;
  // r0: MUL accumulator / partial remainder
  // r1: shifting multiplicand / dividend shifting into quotient
  // r2: shifting multiplier / divisor
  logic [WIDTH-1:0] r0, r0_nxt;
  logic [WIDTH-1:0] r1, r1_nxt;
  logic [WIDTH-1:0] r2, r2_nxt;
  logic [WIDTH-1:0] res_r, res_nxt;
  logic             n_r, n_nxt;
  logic             z_r, z_nxt;
  logic             p_r, p_nxt;
  logic             dz_r, dz_nxt;

  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] fin;
  logic             upd;
  logic             dz_val;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Single-cycle results come straight from the operands presented at acceptance.
  always_comb begin
    quick_res = '0;
    case (bus.op)
      OP_ADD:         quick_res = bus.a + bus.b;
      OP_NOT:         quick_res = ~bus.a;
      OP_SUB:         quick_res = bus.a - bus.b;
      OP_AND:         quick_res = bus.a & bus.b;
      OP_OR:          quick_res = bus.a | bus.b;
      OP_XOR:         quick_res = bus.a ^ bus.b;
      OP_SHL:         quick_res = bus.a << 1;
      OP_SHR:         quick_res = bus.a >> 1;
      OP_PA0, OP_PA1: quick_res = bus.a;
      default:        quick_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    r0_nxt    = r0;
    r1_nxt    = r1;
    r2_nxt    = r2;
    res_nxt   = res_r;
    n_nxt     = n_r;
    z_nxt     = z_r;
    p_nxt     = p_r;
    dz_nxt    = dz_r;
    fin       = '0;
    upd       = 1'b0;
    dz_val    = 1'b0;
    // Restoring-division trial: shift next dividend bit into the remainder and
    // try subtracting the divisor; the borrow bit decides restore vs keep.
    shifted   = {r0, r1[WIDTH-1]};
    diff      = shifted - {1'b0, r2};

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_nxt = bus.op;
          if (bus.op == OP_MUL || bus.op == OP_DIV || bus.op == OP_MOD) begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(WIDTH);
            r0_nxt    = '0;
            r1_nxt    = bus.a;
            r2_nxt    = bus.b;
          end else begin
            state_nxt = DONE;
            if (bus.op != OP_HOLD) begin
              upd = 1'b1;
              fin = quick_res;
            end
          end
        end
      end

      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (op_r == OP_MUL) begin
          if (r2[0]) r0_nxt = r0 + r1;
          r1_nxt = r1 << 1;
          r2_nxt = r2 >> 1;
        end else if (!diff[WIDTH]) begin
          r0_nxt = diff[WIDTH-1:0];
          r1_nxt = {r1[WIDTH-2:0], 1'b1};
        end else begin
          r0_nxt = shifted[WIDTH-1:0];
          r1_nxt = {r1[WIDTH-2:0], 1'b0};
        end
        // A zero divisor naturally yields an all-ones quotient and leaves the
        // dividend as remainder, so no special-case datapath is needed.
        if (cnt_nxt == '0) begin
          state_nxt = DONE;
          upd       = 1'b1;
          dz_val    = (op_r != OP_MUL) && (r2 == '0);
          fin       = (op_r == OP_DIV) ? r1_nxt : r0_nxt;
        end
      end

      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (upd) begin
      res_nxt = fin;
      n_nxt   = fin[WIDTH-1];
      z_nxt   = (fin == '0);
      p_nxt   = !fin[WIDTH-1] && (fin != '0);
      dz_nxt  = dz_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      res_r <= '0;
      n_r   <= 1'b0;
      z_r   <= 1'b1;
      p_r   <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_nxt;
      r0    <= r0_nxt;
      r1    <= r1_nxt;
      r2    <= r2_nxt;
      res_r <= res_nxt;
      n_r   <= n_nxt;
      z_r   <= z_nxt;
      p_r   <= p_nxt;
      dz_r  <= dz_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_r;
  assign bus.n         = n_r;
  assign bus.z         = z_r;
  assign bus.p         = p_r;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(16)) bus16 ();
  alu_mc_if #(.WIDTH(8))  bus8 ();

  alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Shared drivers steered to whichever DUT is selected by use8.
  bit          use8 = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [3:0]  drv_op = '0;
  logic [31:0] drv_a = '0;
  logic [31:0] drv_b = '0;

  assign bus16.in_valid  = drv_valid & ~use8;
  assign bus16.out_ready = drv_ready & ~use8;
  assign bus16.op        = drv_op;
  assign bus16.a         = drv_a[15:0];
  assign bus16.b         = drv_b[15:0];
  assign bus8.in_valid   = drv_valid & use8;
  assign bus8.out_ready  = drv_ready & use8;
  assign bus8.op         = drv_op;
  assign bus8.a          = drv_a[7:0];
  assign bus8.b          = drv_b[7:0];

  logic [31:0] o_res;
  logic        o_n, o_z, o_p, o_dz, o_ov, o_ir;
  assign o_res = use8 ? {24'd0, bus8.res} : {16'd0, bus16.res};
  assign o_n   = use8 ? bus8.n         : bus16.n;
  assign o_z   = use8 ? bus8.z         : bus16.z;
  assign o_p   = use8 ? bus8.p         : bus16.p;
  assign o_dz  = use8 ? bus8.dz        : bus16.dz;
  assign o_ov  = use8 ? bus8.out_valid : bus16.out_valid;
  assign o_ir  = use8 ? bus8.in_ready  : bus16.in_ready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        n, z, p, dz;
    int          lat;
  } mres_t;

  // Behavioural reference: plain arithmetic masked to the width.
  function automatic mres_t model(input int w, input int op, input longint unsigned a,
                                  input longint unsigned b, input mres_t prev);
    longint unsigned mask;
    longint unsigned r;
    mres_t o;
    mask  = (64'd1 << w) - 1;
    o     = prev;
    o.lat = (op == 6 || op == 9 || op == 10) ? w + 1 : 1;
    if (op == 15) return o;
    case (op)
      0:       r = a + b;
      1:       r = ~a;
      2:       r = a - b;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = a * b;
      7:       r = a << 1;
      8:       r = a >> 1;
      9:       r = (b == 0) ? mask : a / b;
      10:      r = (b == 0) ? a : a % b;
      11, 12:  r = a;
      default: r = 0;
    endcase
    r     = r & mask;
    o.res = r[31:0];
    o.n   = r[w-1];
    o.z   = (r == 0);
    o.p   = !o.n && !o.z;
    o.dz  = (op == 9 || op == 10) && (b == 0);
    return o;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_res"}, o_res, 32'd0);
    check({tag, "_rst_nzp"}, {29'd0, o_n, o_z, o_p}, {29'd0, 3'b010});
    check({tag, "_rst_dz"},  {31'd0, o_dz}, 32'd0);
    check({tag, "_rst_hs"},  {30'd0, o_ov, o_ir}, {30'd0, 2'b01});
  endtask

  // Issue one request on the selected DUT and collect the completed result.
  // Operands are scrambled right after acceptance; out_ready toggles randomly
  // while out_valid is low; the result is held for 'stall' cycles first.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall, output mres_t got);
    bit busy_ok;
    bit stable_ok;
    logic [31:0] r0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    check({nm, "_ready_idle"}, {31'd0, o_ir}, 32'd1);
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
    drv_valid = 1'b1;
    drv_ready = 1'b0;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_op    = 4'($urandom);
    drv_a     = $urandom;
    drv_b     = $urandom;
    got.lat   = 1;
    while (!o_ov && got.lat < 200) begin
      if (o_ir) busy_ok = 1'b0;
      drv_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      got.lat++;
    end
    drv_ready = 1'b0;
    got.res = o_res;
    got.n   = o_n;
    got.z   = o_z;
    got.p   = o_p;
    got.dz  = o_dz;
    r0      = o_res;
    check({nm, "_busy_noready"}, {31'd0, busy_ok}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!o_ov || o_ir || o_res !== r0) stable_ok = 1'b0;
    end
    if (stall > 0) check({nm, "_stall_stable"}, {31'd0, stable_ok}, 32'd1);
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    check({nm, "_back_idle"}, {30'd0, o_ov, o_ir}, {30'd0, 2'b01});
  endtask

  task automatic compare(input string nm, input mres_t got, input mres_t exp);
    check({nm, "_res"}, got.res, exp.res);
    check({nm, "_nzp"}, {29'd0, got.n, got.z, got.p}, {29'd0, exp.n, exp.z, exp.p});
    check({nm, "_dz"},  {31'd0, got.dz}, {31'd0, exp.dz});
    check({nm, "_lat"}, got.lat, exp.lat);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    int          stall;
    mres_t       exp;
  } vec_t;

  vec_t  vecs[$];
  mres_t got, exp, m;
  bit    quiet;

  initial begin
    vecs.push_back('{4'd0,  32'h7FFF, 32'h0001, 0, '{32'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd6,  32'h0123, 32'h0010, 0, '{32'h1230, 1'b0, 1'b0, 1'b1, 1'b0, 17}});
    vecs.push_back('{4'd9,  32'd100,  32'd7,    0, '{32'd14,   1'b0, 1'b0, 1'b1, 1'b0, 17}});
    vecs.push_back('{4'd10, 32'd100,  32'd7,    0, '{32'd2,    1'b0, 1'b0, 1'b1, 1'b0, 17}});
    vecs.push_back('{4'd9,  32'd5,    32'd0,    0, '{32'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 17}});
    vecs.push_back('{4'd2,  32'd5,    32'd5,    0, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd15, 32'h1234, 32'h0042, 5, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd1,  32'h00FF, 32'h0000, 0, '{32'hFF00, 1'b1, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd7,  32'h8001, 32'h0000, 0, '{32'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'd8,  32'h8001, 32'h0000, 0, '{32'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'd10, 32'd5,    32'd0,    0, '{32'd5,    1'b0, 1'b0, 1'b1, 1'b1, 17}});
    vecs.push_back('{4'd15, 32'hAAAA, 32'h0000, 1, '{32'd5,    1'b0, 1'b0, 1'b1, 1'b1, 1}});
    vecs.push_back('{4'd13, 32'hFFFF, 32'h0000, 0, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd5,  32'hFFFF, 32'h0F0F, 0, '{32'hF0F0, 1'b1, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd3,  32'hF0F0, 32'h0FF0, 2, '{32'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'd4,  32'h1000, 32'h0001, 0, '{32'h1001, 1'b0, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'd11, 32'h8000, 32'h0001, 0, '{32'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd12, 32'h0000, 32'h0001, 0, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'd14, 32'h1234, 32'h5678, 0, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1}});

    // Reset both DUTs and check the reset state of each.
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    use8 = 1'b0;
    check_reset_state("w16");
    use8 = 1'b1;
    check_reset_state("w8");
    use8 = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, got);
      compare($sformatf("v%0d", i), got, vecs[i].exp);
    end

    // Reset in the middle of a MUL: abandoned, no stale out_valid afterwards.
    drv_op = 4'd6; drv_a = 32'h0123; drv_b = 32'h0010; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("mulrst_busy", {30'd0, o_ov, o_ir}, 32'd0);
    do_reset();
    check_reset_state("mulrst");
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (o_ov || !o_ir) quiet = 1'b0;
    end
    drv_ready = 1'b0;
    check("mulrst_no_stale", {31'd0, quiet}, 32'd1);

    // Randomised traffic on the 16-bit DUT against the model.
    do_reset();
    m = '{32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom & 32'hFFFF;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'hFFFF);
      m   = model(16, int'(rop), longint'(ra), longint'(rb), m);
      run_op($sformatf("r16_%0d_op%0d", i, rop), rop, ra, rb, $urandom_range(0, 2), got);
      compare($sformatf("r16_%0d_op%0d", i, rop), got, m);
    end

    // WIDTH=8 instance: wrap corner cases then random traffic.
    use8 = 1'b1;
    do_reset();
    run_op("w8_add", 4'd0, 32'hFF, 32'h01, 0, got);
    compare("w8_add", got, '{32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    run_op("w8_mul", 4'd6, 32'h10, 32'h10, 0, got);
    compare("w8_mul", got, '{32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9});
    m = '{32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom & 32'hFF;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom & 32'hFF);
      m   = model(8, int'(rop), longint'(ra), longint'(rb), m);
      run_op($sformatf("r8_%0d_op%0d", i, rop), rop, ra, rb, $urandom_range(0, 2), got);
      compare($sformatf("r8_%0d_op%0d", i, rop), got, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
